// File: rtl/dma_bus_arbiter_pkg.sv
// Shared types and address map for the OAM DMA bus arbiter.
package dma_bus_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, START, READ, WRITE} dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] HRAM_LO      = 16'hFF80;
    localparam logic [15:0] HRAM_HI      = 16'hFFFE;

    function automatic logic is_hram(input logic [15:0] addr);
        return (addr >= HRAM_LO) && (addr <= HRAM_HI);
    endfunction

endpackage

// File: rtl/dma_bus_arbiter_dma_engine.sv
// OAM DMA engine: DMA register, transfer FSM, source/index tracking and byte buffer.
// Optional OAM_DMA_RESTART_EN: a register write during a transfer restarts it.
module dma_engine
    import dma_bus_arbiter_pkg::*;
#(
    parameter int DMA_LEN = 160
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_wr,
    input  logic [7:0]  reg_wdata,
    input  logic        hold,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  dma_reg,
    output logic        dma_active,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata
);

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    dma_state_t  state;
    logic [7:0]  idx;
    logic [15:0] src;
    logic [7:0]  byte_q;
    logic        load;

`ifdef OAM_DMA_RESTART_EN
    assign load = reg_wr;
`else
    assign load = reg_wr && (state == IDLE);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 8'h00;
            src        <= 16'h0000;
            byte_q     <= 8'h00;
            dma_reg    <= 8'h00;
            dma_active <= 1'b0;
        end else begin
            if (reg_wr)
                dma_reg <= reg_wdata;
            if (load) begin
                state      <= START;
                src        <= {reg_wdata, 8'h00};
                idx        <= 8'h00;
                dma_active <= 1'b1;
            end else if (!hold) begin
                // A preempting HRAM access freezes the engine for that cycle
                case (state)
                    START: state <= READ;
                    READ: begin
                        byte_q <= mem_rdata;
                        state  <= WRITE;
                    end
                    WRITE: begin
                        if (idx == LAST_IDX) begin
                            state      <= IDLE;
                            dma_active <= 1'b0;
                        end else begin
                            idx   <= idx + 8'd1;
                            state <= READ;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;
        bus_addr  = 16'h0000;
        bus_wdata = 8'h00;
        if (!hold) begin
            case (state)
                READ: begin
                    bus_rd   = 1'b1;
                    bus_addr = src + {8'h00, idx};
                end
                WRITE: begin
                    bus_wr    = 1'b1;
                    bus_addr  = OAM_BASE + {8'h00, idx};
                    bus_wdata = byte_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Shared-bus arbiter between the CPU and the OAM DMA engine (address decode + grant mux).
// Build option OAM_DMA_RESTART_EN is handled inside dma_engine.
module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int DMA_LEN = 160
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active
);

    logic        hit_reg;
    logic        hit_hram;
    logic        cpu_grant;
    logic        reg_wr;
    logic        hold;
    logic [7:0]  dma_reg;
    logic        dma_rd;
    logic        dma_wr;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;

    assign hit_reg  = (cpu_addr == DMA_REG_ADDR);
    assign hit_hram = is_hram(cpu_addr);
    // Reset also blocks CPU pass-through so the bus is quiet while rst_n is low
    assign cpu_grant = rst_n && (cpu_rd || cpu_wr) && !hit_reg && (!dma_active || hit_hram);
    assign reg_wr    = cpu_wr && hit_reg;
    assign hold      = cpu_grant && dma_active;

    dma_engine #(.DMA_LEN(DMA_LEN)) u_engine (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_wr     (reg_wr),
        .reg_wdata  (cpu_wdata),
        .hold       (hold),
        .mem_rdata  (mem_rdata),
        .dma_reg    (dma_reg),
        .dma_active (dma_active),
        .bus_rd     (dma_rd),
        .bus_wr     (dma_wr),
        .bus_addr   (dma_addr),
        .bus_wdata  (dma_wdata)
    );

    always_comb begin
        mem_rd    = dma_rd;
        mem_wr    = dma_wr;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        if (cpu_grant) begin
            mem_rd    = cpu_rd && !cpu_wr;
            mem_wr    = cpu_wr;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wr ? cpu_wdata : 8'h00;
        end
    end

    // A simultaneous write wins; blocked or colliding reads see open bus
    always_comb begin
        cpu_rdata = 8'hFF;
        if (cpu_rd && !cpu_wr) begin
            if (hit_reg)
                cpu_rdata = dma_reg;
            else if (cpu_grant)
                cpu_rdata = mem_rdata;
        end
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed, scoreboard-based bench for dma_bus_arbiter with a behavioural shared memory.
module tb_dma_bus_arbiter;

    localparam int DMA_LEN = 160;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_rdata;
    logic        dma_active;

    bit   [7:0]  wdat  [65536];
    bit          wmask [65536];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   act_cnt = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    int   wr_all = 0;
    bit   last_rd = 1'b0;

    dma_bus_arbiter #(.DMA_LEN(DMA_LEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_rdata  (cpu_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_rdata  (mem_rdata),
        .dma_active (dma_active)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [15:0] a);
        if (a[15:8] == 8'hC0) return a[7:0];
        if (a[15:8] == 8'hD0) return a[7:0] ^ 8'hA5;
        if (a == 16'hFF90) return 8'h77;
        return 8'h00;
    endfunction

    function automatic logic [7:0] rd_model(input logic [15:0] a);
        return wmask[a] ? wdat[a] : init_val(a);
    endfunction

    always @* begin
        mem_rdata = 8'h00;
        if (mem_rd)
            mem_rdata = wmask[mem_addr] ? wdat[mem_addr] : init_val(mem_addr);
    end

    always @(posedge clk) begin
        if (mem_wr) begin
            wdat[mem_addr]  <= mem_wdata;
            wmask[mem_addr] <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (rst_n) begin
            if (dma_active) act_cnt++;
            if (mem_wr) wr_all++;
            if (dma_active && mem_rd && !(mem_addr >= 16'hFF80 && mem_addr <= 16'hFFFE)) begin
                rd_cnt++;
                last_rd = 1'b1;
            end
            if (dma_active && mem_wr) begin
                wr_cnt++;
                check("alternate", last_rd, 1);
                last_rd = 1'b0;
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_extra_write: observed write %0h expected none", mem_addr);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("sb_addr", mem_addr, e.addr);
                    check("sb_data", mem_wdata, e.data);
                end
            end
        end
    endtask

    task automatic mid();
        @(negedge clk);
        monitor();
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        mid();
        fin();
    endtask

    task automatic push_exp(input logic [7:0] hi);
        exp_t e;
        for (int i = 0; i < DMA_LEN; i++) begin
            e.addr = 16'hFE00 + 16'(i);
            e.data = rd_model({hi, 8'(i)});
            sb.push_back(e);
        end
    endtask

    task automatic kick(input logic [7:0] hi);
        push_exp(hi);
        cpu_wr = 1'b1; cpu_addr = 16'hFF46; cpu_wdata = hi;
        mid();
        check("kick_not_forwarded", {mem_rd, mem_wr}, 0);
        fin();
        cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    endtask

    task automatic wait_write(input logic [15:0] addr);
        bit hit = 1'b0;
        for (int i = 0; i < 700 && !hit; i++) begin
            mid();
            hit = dma_active && mem_wr && (mem_addr == addr);
            fin();
        end
        check("wait_write", hit, 1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 800 && !done; i++) begin
            mid();
            done = !dma_active;
            fin();
        end
        check("wait_idle", done, 1);
    endtask

    function automatic int oam_bad(input logic [7:0] hi);
        int bad = 0;
        for (int i = 0; i < DMA_LEN; i++)
            if (rd_model(16'hFE00 + 16'(i)) != init_val({hi, 8'(i)})) bad++;
        return bad;
    endfunction

    initial begin
        int a0;
        int w0;
        rst_n = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_rd = 1'b0; cpu_wr = 1'b0;
        #3;
        check("rst_active", dma_active, 0);
        check("rst_strobes", {mem_rd, mem_wr}, 0);
        check("rst_addr", mem_addr, 0);
        cpu_rd = 1'b1; cpu_addr = 16'hFF46;
        #1;
        check("rst_dma_reg", cpu_rdata, 8'h00);
        cpu_rd = 1'b0; cpu_addr = 16'h0000;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        a0 = act_cnt;
        repeat (5) tick();
        check("no_dma_after_reset", act_cnt - a0, 0);

        // Idle pass-through
        cpu_rd = 1'b1; cpu_addr = 16'hC005;
        mid();
        check("pt_rd_strobe", {mem_rd, mem_wr}, 2'b10);
        check("pt_rd_addr", mem_addr, 16'hC005);
        check("pt_rd_data", cpu_rdata, 8'h05);
        fin();
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 16'hC100; cpu_wdata = 8'h5A;
        mid();
        check("pt_wr_strobe", {mem_rd, mem_wr}, 2'b01);
        check("pt_wr_addr", mem_addr, 16'hC100);
        check("pt_wr_data", mem_wdata, 8'h5A);
        fin();
        check("pt_wr_mem", rd_model(16'hC100), 8'h5A);
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'hC101; cpu_wdata = 8'h11;
        mid();
        check("both_rdata", cpu_rdata, 8'hFF);
        check("both_strobe", {mem_rd, mem_wr}, 2'b01);
        fin();
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        mid();
        check("quiet_bus", {mem_rd, mem_wr, mem_addr, mem_wdata}, 0);
        fin();

        // Basic transfer from 0xC000
        a0 = act_cnt; rd_cnt = 0; wr_cnt = 0;
        kick(8'hC0);
        wait_idle();
        check("basic_active_cycles", act_cnt - a0, 321);
        check("basic_reads", rd_cnt, DMA_LEN);
        check("basic_writes", wr_cnt, DMA_LEN);
        check("basic_sb_drained", sb.size(), 0);
        check("basic_oam", oam_bad(8'hC0), 0);

        // HRAM preemption during the 10th WRITE
        a0 = act_cnt;
        kick(8'hD0);
        wait_write(16'hFE08);
        tick();
        cpu_rd = 1'b1; cpu_addr = 16'hFF90;
        mid();
        check("pre_rd_strobe", {mem_rd, mem_wr}, 2'b10);
        check("pre_addr", mem_addr, 16'hFF90);
        check("pre_rdata", cpu_rdata, 8'h77);
        check("pre_active", dma_active, 1);
        fin();
        cpu_rd = 1'b0; cpu_addr = 16'h0000;
        mid();
        check("pre_resume_wr", mem_wr, 1);
        check("pre_resume_addr", mem_addr, 16'hFE09);
        fin();
        wait_idle();
        check("pre_active_cycles", act_cnt - a0, 322);
        check("pre_oam", oam_bad(8'hD0), 0);

        // Blocked CPU accesses during DMA
        a0 = act_cnt;
        kick(8'hC0);
        wait_write(16'hFE04);
        cpu_rd = 1'b1; cpu_addr = 16'h8000;
        mid();
        check("blk_rdata", cpu_rdata, 8'hFF);
        check("blk_rd_bus", {mem_rd, mem_addr}, {1'b1, 16'hC005});
        fin();
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 16'hC100; cpu_wdata = 8'h33;
        mid();
        check("blk_wr_bus", {mem_wr, mem_addr, mem_wdata}, {1'b1, 16'hFE05, 8'h05});
        fin();
        cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 16'hFF46; cpu_wdata = 8'h00;
        mid();
        check("dma_reg_during", cpu_rdata, 8'hC0);
        check("dma_reg_bus", mem_addr, 16'hC006);
        fin();
        cpu_rd = 1'b0; cpu_addr = 16'h0000;
        wait_idle();
        check("blk_active_cycles", act_cnt - a0, 321);
        check("blk_mem_kept", rd_model(16'hC100), 8'h5A);
        check("blk_oam", oam_bad(8'hC0), 0);

        // Reset in the middle of a transfer
        kick(8'hD0);
        wait_write(16'hFE31);
        rst_n = 1'b0;
        #1;
        check("mid_rst_active", dma_active, 0);
        check("mid_rst_strobes", {mem_rd, mem_wr}, 0);
        cpu_rd = 1'b1; cpu_addr = 16'hFF46;
        #1;
        check("mid_rst_dma_reg", cpu_rdata, 8'h00);
        cpu_rd = 1'b0; cpu_addr = 16'h0000;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        a0 = act_cnt; w0 = wr_all;
        repeat (30) tick();
        check("post_rst_no_dma", act_cnt - a0, 0);
        check("post_rst_no_wr", wr_all - w0, 0);
        check("rst_last_written", rd_model(16'hFE31), 8'h31 ^ 8'hA5);
        check("rst_not_written", rd_model(16'hFE32), 8'h32);

        // 0xFF46 write at idx 20
        a0 = act_cnt;
        kick(8'hC0);
        wait_write(16'hFE13);
        cpu_wr = 1'b1; cpu_addr = 16'hFF46; cpu_wdata = 8'hD0;
`ifdef OAM_DMA_RESTART_EN
        sb.delete();
        push_exp(8'hD0);
`endif
        mid();
        check("rs_wr_not_fwd", {mem_rd, mem_wr, mem_addr}, {2'b10, 16'hC014});
        fin();
        cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_wdata = 8'h00;
        mid();
        check("rs_dma_reg", cpu_rdata, 8'hD0);
`ifdef OAM_DMA_RESTART_EN
        check("rs_next_state", {mem_rd, mem_wr}, 2'b00);
`else
        check("rs_next_state", {mem_rd, mem_wr, mem_addr}, {2'b01, 16'hFE14});
`endif
        fin();
        cpu_rd = 1'b0; cpu_addr = 16'h0000;
        wait_idle();
        check("rs_sb_drained", sb.size(), 0);
`ifdef OAM_DMA_RESTART_EN
        check("rs_active_cycles", act_cnt - a0, 363);
        check("rs_oam", oam_bad(8'hD0), 0);
`else
        check("rs_active_cycles", act_cnt - a0, 321);
        check("rs_oam", oam_bad(8'hC0), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_bus_arbiter.md
DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter DMA_LEN, default 160, SHALL set bytes per OAM DMA transfer; legal range 1..256.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cpu_addr  input  16  CPU bus address.
REQ-006 cpu_wdata  input  8  CPU write data.
REQ-007 cpu_rd  input  1  CPU read strobe, one cycle per access.
REQ-008 cpu_wr  input  1  CPU write strobe, one cycle per access.
REQ-009 cpu_rdata  output  8  CPU read data, combinational, same cycle as cpu_rd.
REQ-010 mem_addr  output  16  shared memory bus address.
REQ-011 mem_wdata  output  8  shared memory bus write data.
REQ-012 mem_rd  output  1  shared bus read strobe.
REQ-013 mem_wr  output  1  shared bus write strobe.
REQ-014 mem_rdata  input  8  shared bus read data, combinationally valid in the mem_rd cycle.
REQ-015 dma_active  output  1  high while a DMA transfer is in progress.

Function
REQ-016 FSM states SHALL be IDLE, START, READ and WRITE; dma_active SHALL be high in START, READ and WRITE.
REQ-017 A cpu_wr to 0xFF46 SHALL load dma_reg with cpu_wdata and SHALL never be forwarded to the mem bus.
REQ-018 A cpu_rd of 0xFF46 SHALL return dma_reg and SHALL never be forwarded to the mem bus.
REQ-019 A 0xFF46 write in IDLE SHALL do the following on the next edge: enter START, set src to {cpu_wdata,8'h00}, and clear idx to 0.
REQ-020 START SHALL last one cycle with no bus use, then go to READ.
REQ-021 READ SHALL drive mem_rd=1 and mem_addr=src+idx, and SHALL capture mem_rdata into byte_q on the edge.
REQ-022 WRITE SHALL drive mem_wr=1, mem_addr=0xFE00+idx and mem_wdata=byte_q. If idx==DMA_LEN-1 the FSM SHALL go to IDLE; otherwise idx SHALL increment and the FSM SHALL go to READ.
REQ-023 An unpreempted transfer SHALL occupy exactly 1+2*DMA_LEN cycles, i.e. 321 at the default.
REQ-024 In IDLE, CPU accesses other than 0xFF46 SHALL pass straight to the mem bus, with cpu_rdata=mem_rdata.
REQ-025 While dma_active, CPU accesses to HRAM (0xFF80-0xFFFE) SHALL take the bus for that cycle, and the DMA SHALL hold its state and idx (preemption).
REQ-026 While dma_active, CPU reads of any other address except 0xFF46 SHALL return 8'hFF, and CPU writes to those addresses SHALL be dropped; neither SHALL stall or reach the bus.
REQ-027 When cpu_rd and cpu_wr are both high, the write SHALL win and the read SHALL return 8'hFF.
REQ-028 When no access is granted, mem_rd, mem_wr, mem_addr and mem_wdata SHALL be 0.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, set idx, src, byte_q and dma_reg to 0, and drive dma_active, mem_rd and mem_wr low; this includes a reset in the middle of a transfer.
REQ-030 After reset release, no DMA SHALL start until a new 0xFF46 write.

Configuration
REQ-031 With OAM_DMA_RESTART_EN defined, a 0xFF46 write while dma_active SHALL restart the transfer: enter START, load the new src and set idx to 0.
REQ-032 Without OAM_DMA_RESTART_EN, a 0xFF46 write while dma_active SHALL update only dma_reg, and the transfer SHALL continue unchanged.

Structure
REQ-033 The shared constants package SHALL hold dma_state_t, DMA_REG_ADDR (16'hFF46), OAM_BASE (16'hFE00), HRAM_LO (16'hFF80) and HRAM_HI (16'hFFFE).
REQ-034 The FSM, idx counter, src and byte_q SHALL live in sub-module dma_engine; the top level SHALL hold only address decode and the grant mux.

Verification
REQ-035 Write 0x C0 to 0xFF46 from IDLE, memory 0xC000+i=i -> exactly 160 reads then 160 writes alternating, OAM 0xFE00+i=i, and dma_active high for exactly 321 cycles.
REQ-036 CPU reads 0xFF90 at the 10th WRITE cycle -> the CPU gets HRAM data, the DMA resumes the same write next cycle, OAM is intact, and the total is 322 cycles.
REQ-037 During DMA, the CPU reads 0x8000 and writes 0xC100 -> the read returns 0xFF, memory 0xC100 is unchanged, and there is no bus strobe.
REQ-038 Assert rst_n low at idx=50 -> dma_active is 0 immediately, no further mem_wr occurs, and dma_reg reads 0x00.
REQ-039 Write 0xD0 to 0xFF46 at idx=20 -> with the macro, the transfer restarts from 0xD000 with a new 321-cycle count; without it, the copy continues from the original src and dma_reg reads 0xD0.
